// File: rtl/axi_to_wb.sv
// AXI-Lite (aw/w/ar/r, no B channel) to Wishbone classic bridge, one transaction in flight.
// Optional ack timeout enabled by defining AXI2WB_TIMEOUT_EN.
module axi_to_wb #(
    parameter int          ADDR_W         = 12,
    parameter logic [31:0] WB_BASE        = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i
);

    typedef enum logic [2:0] {IDLE, WR_CYC, WR_DONE, RD_CYC, RD_DATA} state_t;

    state_t      state_q, state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        timeout_hit;
    logic        wr_req;

    assign wr_req = awvalid && wvalid;

`ifdef AXI2WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is zero on the first cycle of a bus cycle; firing on TIMEOUT_CYCLES-1
    // keeps cyc high for exactly TIMEOUT_CYCLES cycles.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == WR_CYC || state_q == RD_CYC) && !wbm_ack_i) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = WR_CYC;
                end else if (arvalid) begin
                    state_d = RD_CYC;
                end
            end
            WR_CYC: begin
                if (wbm_ack_i || timeout_hit) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: state_d = IDLE;
            RD_CYC: begin
                if (wbm_ack_i || timeout_hit) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid_q && rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered output values for the next cycle, derived from the current state
    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        cyc_d     = 1'b0;
        stb_d     = 1'b0;
        we_d      = 1'b0;
        sel_d     = 4'h0;
        adr_d     = adr_q;
        dat_d     = dat_q;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    sel_d = 4'hF;
                    adr_d = 32'(awaddr) | WB_BASE;
                    dat_d = wdata;
                end else if (arvalid) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    sel_d = 4'hF;
                    adr_d = 32'(araddr) | WB_BASE;
                end
            end
            WR_CYC: begin
                if (wbm_ack_i || timeout_hit) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    sel_d = 4'hF;
                end
            end
            RD_CYC: begin
                // A real ack outranks a simultaneous timeout
                if (wbm_ack_i) begin
                    rvalid_d = 1'b1;
                    rdata_d  = wbm_dat_i;
                end else if (timeout_hit) begin
                    rvalid_d = 1'b1;
                    rdata_d  = 32'hDEAD_BEEF;
                end else begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    sel_d = 4'hF;
                end
            end
            RD_DATA: begin
                rvalid_d = !(rvalid_q && rready);
            end
            default: ;
        endcase
    end

    assign arready   = (state_q == IDLE) && arvalid && !wr_req && axis_rst_n;
    assign awready   = awready_q;
    assign wready    = wready_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_axi_to_wb.sv
// Directed self-checking bench for axi_to_wb; the timeout section runs when AXI2WB_TIMEOUT_EN is defined.
module tb_axi_to_wb;

    logic        clk;
    logic        rst_n;
    logic        awvalid, wvalid, arvalid, rready;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    axi_to_wb #(
        .ADDR_W        (12),
        .WB_BASE       (32'h3000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .axis_clk  (clk),
        .axis_rst_n(rst_n),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0;
        wbm_dat_i = '0; wbm_ack_i = 0;

        // Reset state
        #1;
        check("rst_cyc", {31'b0, wbm_cyc_o}, 0);
        check("rst_stb_we", {30'b0, wbm_stb_o, wbm_we_o}, 0);
        check("rst_sel", {28'b0, wbm_sel_o}, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
        check("rst_axi", {28'b0, awready, wready, arready, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Ack in IDLE is ignored
        wbm_ack_i = 1;
        tick();
        wbm_ack_i = 0;
        check("idle_ack_ignored", {29'b0, wbm_cyc_o, awready, rvalid}, 0);

        // Write, ack 3 cycles after stb
        awvalid = 1; wvalid = 1; awaddr = 12'h010; wdata = 32'h0000_000B;
        tick();
        check("wr_cyc", {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b111);
        check("wr_adr", wbm_adr_o, 32'h3000_0010);
        check("wr_dat", wbm_dat_o, 32'h0000_000B);
        check("wr_sel", {28'b0, wbm_sel_o}, 4'hF);
        check("wr_no_ready", {30'b0, awready, wready}, 0);
        tick();
        check("wr_hold", {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b111);
        tick();
        wbm_ack_i = 1;
        tick();
        wbm_ack_i = 0;
        check("wr_ready_pulse", {30'b0, awready, wready}, 2'b11);
        check("wr_cyc_drop", {30'b0, wbm_cyc_o, wbm_stb_o}, 0);
        tick();
        check("wr_ready_once", {30'b0, awready, wready}, 0);
        awvalid = 0; wvalid = 0;
        tick();

        // Read, ack 1 cycle after stb, rready held low 5 cycles
        arvalid = 1; araddr = 12'h000;
        #1;
        check("rd_arready", {31'b0, arready}, 1);
        tick();
        arvalid = 0;
        check("rd_cyc", {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b110);
        check("rd_adr", wbm_adr_o, 32'h3000_0000);
        check("rd_arready_busy", {31'b0, arready}, 0);
        wbm_ack_i = 1; wbm_dat_i = 32'h0000_0004;
        tick();
        wbm_ack_i = 0; wbm_dat_i = 32'hFFFF_FFFF;
        check("rd_cyc_drop", {31'b0, wbm_cyc_o}, 0);
        for (int i = 0; i < 5; i++) begin
            check("rd_rvalid_hold", {31'b0, rvalid}, 1);
            check("rd_rdata_hold", rdata, 32'h0000_0004);
            tick();
        end
        rready = 1;
        tick();
        rready = 0;
        check("rd_rvalid_clear", {31'b0, rvalid}, 0);
        check("rd_rdata_keep", rdata, 32'h0000_0004);
        tick();

        // Simultaneous write and read: write first
        awvalid = 1; wvalid = 1; awaddr = 12'h020; wdata = 32'h5;
        arvalid = 1; araddr = 12'h024;
        #1;
        check("sim_arready_idle", {31'b0, arready}, 0);
        tick();
        check("sim_wr_first", {30'b0, wbm_cyc_o, wbm_we_o}, 2'b11);
        check("sim_wr_adr", wbm_adr_o, 32'h3000_0020);
        check("sim_arready_wr", {31'b0, arready}, 0);
        wbm_ack_i = 1;
        tick();
        wbm_ack_i = 0;
        check("sim_wr_done", {29'b0, awready, wready, arready}, 3'b110);
        tick();
        awvalid = 0; wvalid = 0;
        #1;
        check("sim_arready_after", {31'b0, arready}, 1);
        tick();
        arvalid = 0;
        check("sim_rd_cyc", {30'b0, wbm_cyc_o, wbm_we_o}, 2'b10);
        check("sim_rd_adr", wbm_adr_o, 32'h3000_0024);
        wbm_ack_i = 1; wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 0;
        check("sim_rd_data", rdata, 32'h1234_5678);
        check("sim_rvalid", {31'b0, rvalid}, 1);
        rready = 1;
        tick();
        rready = 0;
        check("sim_rvalid_clear", {31'b0, rvalid}, 0);

        // awvalid alone for 4 cycles, then wvalid
        awvalid = 1; awaddr = 12'h030; wdata = 32'h77;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("aw_only_no_cyc", {30'b0, wbm_cyc_o, awready}, 0);
        end
        wvalid = 1;
        tick();
        check("aw_w_cyc", {30'b0, wbm_cyc_o, wbm_we_o}, 2'b11);
        check("aw_w_adr", wbm_adr_o, 32'h3000_0030);
        check("aw_w_dat", wbm_dat_o, 32'h77);
        wbm_ack_i = 1;
        tick();
        wbm_ack_i = 0;
        check("aw_w_ready", {30'b0, awready, wready}, 2'b11);
        tick();
        awvalid = 0; wvalid = 0;
        tick();

        // Asynchronous reset during RD_CYC
        arvalid = 1; araddr = 12'h008;
        tick();
        arvalid = 0;
        check("rst_mid_cyc_pre", {31'b0, wbm_cyc_o}, 1);
        #2;
        rst_n = 0;
        #1;
        check("rst_mid_cyc", {29'b0, wbm_cyc_o, wbm_stb_o, rvalid}, 0);
        check("rst_mid_adr", wbm_adr_o, 0);
        tick(); tick();
        rst_n = 1;
        tick();
        awvalid = 1; wvalid = 1; awaddr = 12'h010; wdata = 32'hA5A5_0001;
        tick();
        check("post_rst_wr_adr", wbm_adr_o, 32'h3000_0010);
        check("post_rst_wr_dat", wbm_dat_o, 32'hA5A5_0001);
        wbm_ack_i = 1;
        tick();
        wbm_ack_i = 0;
        check("post_rst_wr_ready", {29'b0, awready, wready, wbm_cyc_o}, 3'b110);
        tick();
        awvalid = 0; wvalid = 0;
        tick();

`ifdef AXI2WB_TIMEOUT_EN
        begin
            int cyc_cnt;
            // Write with no ack
            awvalid = 1; wvalid = 1; awaddr = 12'h040; wdata = 32'h9;
            tick();
            cyc_cnt = 0;
            for (int i = 0; i < 40 && wbm_cyc_o; i++) begin
                cyc_cnt++;
                tick();
            end
            check("tmo_wr_cycles", cyc_cnt, 16);
            check("tmo_wr_ready", {30'b0, awready, wready}, 2'b11);
            tick();
            awvalid = 0; wvalid = 0;
            tick();
            // Read with no ack
            arvalid = 1; araddr = 12'h044;
            tick();
            arvalid = 0;
            cyc_cnt = 0;
            for (int i = 0; i < 40 && wbm_cyc_o; i++) begin
                cyc_cnt++;
                tick();
            end
            check("tmo_rd_cycles", cyc_cnt, 16);
            check("tmo_rd_rvalid", {31'b0, rvalid}, 1);
            check("tmo_rd_data", rdata, 32'hDEAD_BEEF);
            rready = 1;
            tick();
            rready = 0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_to_wb.md
Name: axi_to_wb

Overview:
- Bridge: AXI-Lite slave (aw/w/ar/r channels, no B channel) on the front, Wishbone classic master on the back.
- Lets an AXI-Lite initiator (test harness, DMA/controller block) reach Wishbone user-project space at a fixed base address.
- One outstanding transaction at a time.
- Write completes only after the Wishbone ack; read data is returned on the r channel.

Parameters:
- ADDR_W, 12, AXI-Lite address width (awaddr/araddr).
- WB_BASE, 32'h3000_0000, OR-ed onto the zero-extended AXI address to form wbm_adr_o.
- TIMEOUT_CYCLES, 255, ack timeout in cycles; used only when AXI2WB_TIMEOUT_EN is defined.

Ports:
- axis_clk  in  1  clock.
- axis_rst_n  in  1  reset, asynchronous, active-low.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- awaddr  in  ADDR_W  write address.
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- wdata  in  32  write data.
- arvalid  in  1  read address valid.
- arready  out  1  read address accepted.
- araddr  in  ADDR_W  read address.
- rvalid  out  1  read data valid.
- rready  in  1  read data accepted.
- rdata  out  32  read data.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  byte selects; always 4'hF during a cycle.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone ack.

Behaviour:
- Reset (async, axis_rst_n=0): state IDLE. All outputs 0: awready, wready, arready, rvalid, rdata, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o.
- Reset mid-transaction drops wbm_cyc_o/wbm_stb_o immediately; the pending AXI transaction is discarded.
- All outputs are registered except arready.
- arready = (state==IDLE) && arvalid && !(awvalid && wvalid) && axis_rst_n.
- States: IDLE, WR_CYC, WR_DONE, RD_CYC, RD_DATA.
- IDLE:
  - If awvalid && wvalid at edge T0: latch awaddr/wdata; next state WR_CYC.
  - Else if arvalid: arready=1 in the same cycle; latch araddr; next state RD_CYC.
  - Writes take priority over reads when both are presented together.
  - awvalid without wvalid (or the reverse) starts nothing; wait until both are high.
- WR_CYC (from T0+1):
  - cyc=stb=we=1, sel=4'hF, adr=WB_BASE|awaddr, dat=wdata; all held stable.
  - When wbm_ack_i is sampled high at edge Tk: next state WR_DONE; cyc/stb/we drop at Tk+1.
- WR_DONE: awready=wready=1 for exactly one cycle, then IDLE.
  - Minimum write latency: awvalid&wvalid at T0 -> awready at T2, when ack arrives at T1.
  - The AXI master holds awvalid/wvalid until awready/wready.
- RD_CYC (from T0+1): cyc=stb=1, we=0, sel=4'hF, adr=WB_BASE|araddr.
  - On ack at edge Tk: capture wbm_dat_i into rdata; drop cyc/stb; next state RD_DATA.
- RD_DATA:
  - rvalid=1 from Tk+1; rdata stable until the rvalid&&rready handshake.
  - After the handshake: rvalid=0 next cycle, state IDLE.
  - rdata keeps its last value afterwards.
- wbm_ack_i is ignored outside WR_CYC/RD_CYC.
- New AXI requests are not accepted (awready/wready/arready low) while any transaction is in flight.
- Address width: {{(32-ADDR_W){1'b0}}, addr} | WB_BASE.

Optional Feature:
- Macro: AXI2WB_TIMEOUT_EN.
- Defined:
  - An 8-bit-min counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to WR_CYC/RD_CYC and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the cycle terminates as if acked: cyc/stb drop.
  - Write proceeds to WR_DONE.
  - Read returns rdata=32'hDEAD_BEEF.
  - A real ack on the same cycle as the timeout wins; its data is used.
- Not defined: no counter; the bridge waits indefinitely for ack.

Test Plan:
- Write: awaddr=12'h010, wdata=32'h0000_000B; slave acks 3 cycles after stb -> wbm_adr_o=32'h3000_0010, wbm_dat_o=32'hB, we=1, sel=4'hF; awready&wready high for exactly one cycle, the cycle after ack; cyc low in that cycle.
- Read: araddr=12'h000; slave returns 32'h0000_0004 with ack 1 cycle after stb; rready held low 5 cycles -> rvalid stays 1, rdata=32'h4 stable; one cycle after rready, rvalid=0.
- Simultaneous awvalid&wvalid (12'h020, 32'h5) and arvalid (12'h024) in IDLE -> WB write to 32'h3000_0020 first; arready stays 0 until the write is done; then read of 32'h3000_0024 completes.
- awvalid alone for 4 cycles, then wvalid -> wbm_cyc_o stays 0 during the 4 cycles; WB write starts the cycle after wvalid rises.
- axis_rst_n pulled low while wbm_cyc_o=1 in RD_CYC -> cyc/stb/rvalid go 0 without a clock edge; after release, a new write to 12'h010 completes normally.
- With AXI2WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> cyc drops after 16 cycles; read rdata=32'hDEAD_BEEF with rvalid=1; write yields the awready/wready pulse.
